mem_w2_unit: RTL and testbench

Data-memory responder for the second writeback stage (W2) of the pipelined core. It captures load and store requests from the Writeback stage, runs a request/grant/response handshake with external data memory, and drives the byte lanes. For loads it returns the aligned and extended result together with RegWE_W_W2, A4_W2 and ExPathW2. These signals feed the control path's hazard unit for forwarding and load stalls.

---
 rtl/mem_w2_pkg.sv | 24 ++
 rtl/mem_lane_align.sv | 60 ++++++
 rtl/mem_w2_unit.sv | 120 ++++++++++++
 tb/tb_mem_w2_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_w2_pkg.sv
// Shared types and constants for the W2 data-memory responder.
package mem_w2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Funct3 access size / sign encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Execute path tags, shared with the control path's hazard unit
    localparam logic [1:0] EXP_ALU = 2'd0;
    localparam logic [1:0] EXP_MUL = 2'd1;
    localparam logic [1:0] EXP_LSU = 2'd2;
    localparam logic [1:0] EXP_CSR = 2'd3;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication, legality check, and
// load lane extraction with sign/zero extension. Purely combinational.
import mem_w2_pkg::*;

module mem_lane_align (
    input  logic        st_we,
    input  logic [2:0]  st_f3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        bad,
    input  logic [2:0]  ld_f3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [15:0] sh;

    // Request side: lane enables, replicated data, misalign/illegal check
    always_comb begin
        be    = 4'b0000;
        wdata = st_data;
        bad   = 1'b0;
        case (st_f3)
            F3_B, F3_BU: begin
                be    = 4'b0001 << st_off;
                wdata = {4{st_data[7:0]}};
            end
            F3_H, F3_HU: begin
                be    = st_off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
                bad   = st_off[0];
            end
            F3_W: begin
                be  = 4'b1111;
                bad = (st_off != 2'b00);
            end
            default: bad = 1'b1;
        endcase
        // unsigned variants have no store meaning
        if (st_we && st_f3[2])
            bad = 1'b1;
    end

    // Response side: pull the addressed lane down to bit 0 and extend
    always_comb begin
        sh     = 16'(rdata >> {ld_off, 3'b000});
        result = rdata;
        case (ld_f3)
            F3_B:    result = {{24{sh[7]}}, sh[7:0]};
            F3_BU:   result = {24'h0, sh[7:0]};
            F3_H:    result = {{16{sh[15]}}, sh[15:0]};
            F3_HU:   result = {16'h0, sh[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_w2_unit.sv
// W2 data-memory responder: captures a W-stage load/store, runs the
// req/gnt/rvalid handshake and returns the extended load result.
import mem_w2_pkg::*;

module mem_w2_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWriteW,
    input  logic              MemReadW,
    input  logic [1:0]        ExPathW,
    input  logic [4:0]        A3_W,
    input  logic [2:0]        Funct3W,
    input  logic [ADDR_W-1:0] AddrW,
    input  logic [DATA_W-1:0] WriteDataW,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              RegWE_W_W2,
    output logic [4:0]        A4_W2,
    output logic [1:0]        ExPathW2,
    output logic [DATA_W-1:0] ResultW2,
    output logic              MemBusy,
    output logic              MisalignErr
);

    state_e            state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;

    logic [3:0]        be_c;
    logic [DATA_W-1:0] wdata_c;
    logic              bad_c;
    logic [DATA_W-1:0] rd_c;

    mem_lane_align u_align (
        .st_we   (MemWriteW),
        .st_f3   (Funct3W),
        .st_off  (AddrW[1:0]),
        .st_data (WriteDataW),
        .be      (be_c),
        .wdata   (wdata_c),
        .bad     (bad_c),
        .ld_f3   (f3_q),
        .ld_off  (addr_q[1:0]),
        .rdata   (mem_rdata),
        .result  (rd_c)
    );

    // FSM plus capture registers; a store wins if both requests are high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= '0;
            be_q        <= 4'b0000;
            wdata_q     <= '0;
            A4_W2       <= 5'd0;
            ExPathW2    <= 2'd0;
            ResultW2    <= '0;
            MisalignErr <= 1'b0;
        end else begin
            MisalignErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (MemWriteW || MemReadW) begin
                        we_q     <= MemWriteW;
                        f3_q     <= Funct3W;
                        addr_q   <= AddrW;
                        be_q     <= be_c;
                        wdata_q  <= wdata_c;
                        A4_W2    <= A3_W;
                        ExPathW2 <= ExPathW;
                        if (bad_c) MisalignErr <= 1'b1;
                        else       state       <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) state <= we_q ? IDLE : WAIT_R;
                end
                WAIT_R: begin
                    if (mem_rvalid) begin
                        ResultW2 <= rd_c;
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus and writeback outputs decode from state and captured registers only
    always_comb begin
        mem_req    = (state == REQ);
        mem_we     = (state == REQ) && we_q;
        mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
        mem_be     = be_q;
        mem_wdata  = wdata_q;
        MemBusy    = (state != IDLE);
        RegWE_W_W2 = (state == DONE) && (A4_W2 != 5'd0);
    end

    // The control path must hold off new requests while the unit is busy
    a_no_req_busy: assert property (@(posedge clk) disable iff (!reset)
        (state != IDLE) |-> !(MemWriteW || MemReadW))
        else $error("mem_w2_unit: request presented while busy");

endmodule

// File: tb/tb_mem_w2_unit.sv
// Self-checking bench for mem_w2_unit with a scoreboard of load results.
module tb_mem_w2_unit;
    import mem_w2_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWriteW = 1'b0, MemReadW = 1'b0;
    logic [1:0]  ExPathW = '0;
    logic [4:0]  A3_W = '0;
    logic [2:0]  Funct3W = '0;
    logic [31:0] AddrW = '0, WriteDataW = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        RegWE_W_W2, MemBusy, MisalignErr;
    logic [4:0]  A4_W2;
    logic [1:0]  ExPathW2;
    logic [31:0] ResultW2;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  a4;
        logic [1:0]  ep;
        logic        we;
        int          at;
    } exp_t;
    exp_t sb[$];

    mem_w2_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .MemWriteW(MemWriteW), .MemReadW(MemReadW), .ExPathW(ExPathW),
        .A3_W(A3_W), .Funct3W(Funct3W), .AddrW(AddrW), .WriteDataW(WriteDataW),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .RegWE_W_W2(RegWE_W_W2), .A4_W2(A4_W2), .ExPathW2(ExPathW2),
        .ResultW2(ResultW2), .MemBusy(MemBusy), .MisalignErr(MisalignErr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present one W-stage request for one cycle, then scramble the fields
    task automatic do_req(input logic wr, input logic rd, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] a3, input logic [1:0] ep);
        MemWriteW = wr; MemReadW = rd; Funct3W = f3; AddrW = addr;
        WriteDataW = data; A3_W = a3; ExPathW = ep;
        tick();
        MemWriteW = 1'b0; MemReadW = 1'b0;
        Funct3W = 3'($urandom); AddrW = $urandom; WriteDataW = $urandom;
        A3_W = 5'($urandom); ExPathW = 2'($urandom);
    endtask

    task automatic run_store(input string t, input logic rd, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] data, input int g,
                             input logic [3:0] ebe, input logic [31:0] ewd);
        do_req(1'b1, rd, f3, addr, data, 5'd0, EXP_LSU);
        chk({t, "_busy"}, MemBusy, 1);
        chk({t, "_req"}, mem_req, 1);
        chk({t, "_we"}, mem_we, 1);
        chk({t, "_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        chk({t, "_be"}, mem_be, ebe);
        chk({t, "_wdata"}, mem_wdata, ewd);
        for (int i = 0; i < g; i++) begin
            mem_rvalid = 1'b1; mem_rdata = $urandom;
            tick();
            mem_rvalid = 1'b0;
            chk({t, "_hold_req"}, mem_req, 1);
            chk({t, "_hold_wd"}, mem_wdata, ewd);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk({t, "_idle"}, {mem_req, MemBusy, RegWE_W_W2}, 0);
    endtask

    task automatic run_load(input string t, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [4:0] a3, input logic [1:0] ep, input logic [31:0] rdata,
                            input int g, input int r, input logic [31:0] eres);
        exp_t e;
        sb.push_back('{eres, a3, ep, (a3 != 5'd0), cyc + 3 + g + r});
        do_req(1'b0, 1'b1, f3, addr, 32'h0, a3, ep);
        chk({t, "_req"}, mem_req, 1);
        chk({t, "_we"}, mem_we, 0);
        chk({t, "_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        for (int i = 0; i < g; i++) begin
            mem_rvalid = 1'b1; mem_rdata = $urandom;
            tick();
            mem_rvalid = 1'b0;
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk({t, "_wait"}, {mem_req, MemBusy}, 32'h1);
        for (int i = 0; i < r; i++) begin
            mem_rdata = $urandom;
            tick();
            chk({t, "_nowe"}, RegWE_W_W2, 0);
        end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0; mem_rdata = $urandom;
        if (sb.size() == 0) begin
            chk({t, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({t, "_result"}, ResultW2, e.res);
            chk({t, "_a4"}, A4_W2, e.a4);
            chk({t, "_expath"}, ExPathW2, e.ep);
            chk({t, "_regwe"}, RegWE_W_W2, e.we);
            chk({t, "_cycle"}, cyc, e.at);
        end
        tick();
        chk({t, "_pulse"}, {RegWE_W_W2, MemBusy}, 0);
    endtask

    task automatic run_bad(input string t, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr);
        do_req(wr, ~wr, f3, addr, 32'h1234_5678, 5'd3, EXP_LSU);
        chk({t, "_err"}, MisalignErr, 1);
        chk({t, "_noreq"}, {mem_req, MemBusy}, 0);
        tick();
        chk({t, "_err_clr"}, {MisalignErr, mem_req, MemBusy}, 0);
    endtask

    initial begin
        tick(); tick();
        chk("rst_ctl", {mem_req, mem_we, MemBusy, RegWE_W_W2, MisalignErr}, 0);
        chk("rst_data", mem_addr | mem_wdata | ResultW2, 0);
        chk("rst_misc", {mem_be, A4_W2, ExPathW2}, 0);
        reset = 1'b1;
        tick();

        run_store("sw", 1'b0, F3_W, 32'h104, 32'hDEADBEEF, 0, 4'b1111, 32'hDEADBEEF);
        run_store("sb", 1'b0, F3_B, 32'h203, 32'h000000A5, 1, 4'b1000, 32'hA5A5A5A5);
        run_store("sh", 1'b0, F3_H, 32'h206, 32'hFFFF1234, 2, 4'b1100, 32'h12341234);
        run_store("both", 1'b1, F3_W, 32'h400, 32'h0BADF00D, 1, 4'b1111, 32'h0BADF00D);

        run_load("lb", F3_B, 32'h102, 5'd7, EXP_LSU, 32'h00800000, 2, 3, 32'hFFFFFF80);
        run_load("lbu", F3_BU, 32'h102, 5'd9, EXP_MUL, 32'h00800000, 2, 3, 32'h00000080);
        run_load("lh", F3_H, 32'h102, 5'd12, EXP_CSR, 32'h80010000, 0, 0, 32'hFFFF8001);
        run_load("lhu", F3_HU, 32'h102, 5'd31, EXP_ALU, 32'h80010000, 1, 1, 32'h00008001);
        run_load("lw_x0", F3_W, 32'h110, 5'd0, EXP_LSU, 32'h13579BDF, 1, 0, 32'h13579BDF);

        run_bad("lw_mis", 1'b0, F3_W, 32'h102);
        run_bad("lh_mis", 1'b0, F3_H, 32'h101);
        run_bad("sbu_ill", 1'b1, F3_BU, 32'h200);

        // reset while waiting for read data; the late rvalid must be ignored
        do_req(1'b0, 1'b1, F3_W, 32'h300, 32'h0, 5'd5, EXP_LSU);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("pre_rst_busy", MemBusy, 1);
        reset = 1'b0;
        #2;
        chk("mid_rst_ctl", {mem_req, mem_we, MemBusy, RegWE_W_W2, MisalignErr}, 0);
        chk("mid_rst_data", mem_addr | mem_wdata | ResultW2, 0);
        chk("mid_rst_misc", {mem_be, A4_W2, ExPathW2}, 0);
        #2;
        reset = 1'b1;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_rvalid = 1'b0;
        chk("late_rv_idle", {MemBusy, RegWE_W_W2}, 0);
        chk("late_rv_res", ResultW2, 0);
        run_load("post_rst", F3_W, 32'h308, 5'd4, EXP_ALU, 32'h01234567, 0, 2, 32'h01234567);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
